// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issuer: sizing, opcodes, FSM states and the
// program-entry layout.
package alu_pkg;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int LAT   = 3;
   localparam int WW    = $clog2(LAT + 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_NOT = 3'd1;
   localparam logic [2:0] OP_SHL = 3'd2;
   localparam logic [2:0] OP_SHR = 3'd3;
   localparam logic [2:0] OP_EQ  = 3'd4;
   localparam logic [2:0] OP_GT  = 3'd5;
   localparam logic [2:0] OP_STA = 3'd6;
   localparam logic [2:0] OP_STL = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [7:0] instr;
      logic [3:0] a;
      logic [3:0] b;
   } entry_t;

   // Store opcodes drive nothing onto the operator's result mux.
   function automatic logic has_result(input logic [2:0] op);
      return op <= OP_GT;
   endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Operator-side bus: the issuer drives instr/A/B and reads back dato_mux.
interface alu_issuer_if;
   logic [7:0] alu_instr;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [3:0] alu_result;

   modport master (output alu_instr, output alu_a, output alu_b, input alu_result);
   modport slave  (input alu_instr, input alu_a, input alu_b, output alu_result);
endinterface

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH entries of {instr, A, B}, one write port, one async read port.
module alu_prog_mem
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  entry_t        i_wdata,
   input  logic [AW-1:0] i_raddr,
   output entry_t        o_rdata
);

   entry_t r_mem [DEPTH];

   // NOTE: storage array has no reset; contents are undefined until loaded,
   // which keeps it a plain regfile instead of DEPTH*16 resettable flops.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_issuer.sv
// Runs a loaded program of (instr,A,B) entries through the pipelined 4-bit ALU,
// holding operands for LAT cycles and reporting each result with a valid strobe.
module alu_issuer
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load_en,
   input  logic [AW-1:0]   load_addr,
   input  logic [7:0]      load_instr,
   input  logic [3:0]      load_a,
   input  logic [3:0]      load_b,
   input  logic [AW:0]     count,
   input  logic            start,
   alu_issuer_if.master    op,
   output logic            busy,
   output logic            done,
   output logic            res_valid,
   output logic [AW-1:0]   res_idx,
   output logic [2:0]      res_op,
   output logic [3:0]      res_data
);

   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   state_t        r_state;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_last;
   logic [WW-1:0] r_wcnt;
   logic [7:0]    r_alu_instr;
   logic [3:0]    r_alu_a;
   logic [3:0]    r_alu_b;
   logic          r_busy;
   logic          r_done;
   logic          r_res_valid;
   logic [AW-1:0] r_res_idx;
   logic [2:0]    r_res_op;
   logic [3:0]    r_res_data;

   logic          w_we;
   entry_t        w_wdata;
   logic [AW-1:0] w_raddr;
   entry_t        w_rdata;
   entry_t        w_entry;
   logic [AW:0]   w_count_sat;
   logic [2:0]    w_op;

   assign w_we        = load_en && (r_state == S_IDLE);
   assign w_wdata     = '{instr: load_instr, a: load_a, b: load_b};
   assign w_raddr     = (r_state == S_CAPTURE) ? r_pc + AW'(1) : '0;
   // A write to entry 0 in the start cycle is forwarded so the run sees it.
   assign w_entry     = (w_we && load_addr == '0) ? w_wdata : w_rdata;
   assign w_count_sat = (count > DEPTH_C) ? DEPTH_C : count;
   assign w_op        = r_alu_instr[7:5];

   alu_prog_mem u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (load_addr),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= '0;
         r_last      <= '0;
         r_wcnt      <= '0;
         r_alu_instr <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_idx   <= '0;
         r_res_op    <= '0;
         r_res_data  <= '0;
      end else begin
         r_done      <= 1'b0;
         r_res_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_count_sat == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state     <= S_ISSUE;
                     r_busy      <= 1'b1;
                     r_pc        <= '0;
                     r_last      <= AW'(w_count_sat - (AW + 1)'(1));
                     r_alu_instr <= w_entry.instr & 8'hE0;
                     r_alu_a     <= w_entry.a;
                     r_alu_b     <= w_entry.b;
                  end
               end
            end
            S_ISSUE: begin
               r_wcnt  <= WW'(LAT - 1);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               r_wcnt <= r_wcnt - WW'(1);
               if (r_wcnt <= WW'(1)) r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (has_result(w_op)) begin
                  r_res_valid <= 1'b1;
                  r_res_data  <= op.alu_result;
                  r_res_idx   <= r_pc;
                  r_res_op    <= w_op;
               end
               if (r_pc == r_last) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_pc    <= '0;
               end else begin
                  r_pc        <= r_pc + AW'(1);
                  r_state     <= S_ISSUE;
                  r_alu_instr <= w_entry.instr & 8'hE0;
                  r_alu_a     <= w_entry.a;
                  r_alu_b     <= w_entry.b;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign op.alu_instr = r_alu_instr;
   assign op.alu_a     = r_alu_a;
   assign op.alu_b     = r_alu_b;
   assign busy         = r_busy;
   assign done         = r_done;
   assign res_valid    = r_res_valid;
   assign res_idx      = r_res_idx;
   assign res_op       = r_res_op;
   assign res_data     = r_res_data;

endmodule

// File: tb/tb_alu_issuer.sv
// Bench for alu_issuer paired with a 3-stage operator model; a cycle-level
// model of the run schedule checks every output each cycle.
module tb_alu_issuer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_en;
   logic [2:0] load_addr;
   logic [7:0] load_instr;
   logic [3:0] load_a, load_b;
   logic [3:0] count;
   logic       start;
   logic       busy, done, res_valid;
   logic [2:0] res_idx, res_op;
   logic [3:0] res_data;

   alu_issuer_if u_if ();

   alu_issuer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_instr (load_instr),
      .load_a     (load_a),
      .load_b     (load_b),
      .count      (count),
      .start      (start),
      .op         (u_if),
      .busy       (busy),
      .done       (done),
      .res_valid  (res_valid),
      .res_idx    (res_idx),
      .res_op     (res_op),
      .res_data   (res_data)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int alu_fn(input int op, input int a, input int b);
      case (op)
         0: return (a + b) % 16;
         1: return 15 - a;
         2: return (a * 2) % 16;
         3: return a / 2;
         4: return (a == b) ? 1 : 0;
         5: return (a > b) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   // Operator: operand reg, op reg, mux reg.
   logic [2:0] s1_op;
   logic [3:0] s1_a, s1_b, s2, s3;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_op <= '0; s1_a <= '0; s1_b <= '0; s2 <= '0; s3 <= '0;
      end else begin
         s1_op <= u_if.alu_instr[7:5];
         s1_a  <= u_if.alu_a;
         s1_b  <= u_if.alu_b;
         s2    <= 4'(alu_fn(int'(s1_op), int'(s1_a), int'(s1_b)));
         s3    <= s2;
      end
   end
   assign u_if.alu_result = s3;

   // Model state: program contents and the current run's start cycle and length.
   typedef struct { int op; int a; int b; } pent_t;
   pent_t prog [8];
   int    cyc = 0;
   bit    run_valid = 0;
   int    run_start = 0;
   int    run_n = 0;

   always @(posedge clk) begin
      bit m_idle;
      if (!rst_n) run_valid = 0;
      else begin
         m_idle = !run_valid || (cyc - run_start) >= 4 * run_n + 2;
         if (load_en && m_idle)
            prog[load_addr] = '{int'(load_instr[7:5]), int'(load_a), int'(load_b)};
         if (start && m_idle) begin
            run_valid = 1;
            run_start = cyc;
            run_n     = (count > 4'd8) ? 8 : int'(count);
         end
      end
      cyc = cyc + 1;
   end

   int obs_idx[$], obs_data[$];
   int obs_done_t, obs_done_n;

   // Compare process: every cycle, outputs against the schedule implied by the model.
   always @(negedge clk) begin
      int t, k, e_busy, e_done, e_rv;
      if (!rst_n) begin
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_res_valid", res_valid, 0);
         check("rst_alu_instr", u_if.alu_instr, 0);
         check("rst_alu_a", u_if.alu_a, 0);
         check("rst_alu_b", u_if.alu_b, 0);
      end else begin
         e_busy = 0; e_done = 0; e_rv = 0; t = -1;
         if (run_valid) begin
            t      = cyc - run_start;
            e_busy = (t >= 1 && t <= 4 * run_n) ? 1 : 0;
            e_done = (t == 4 * run_n + 1) ? 1 : 0;
            if (t >= 1 && t <= 4 * run_n) begin
               k = (t - 1) / 4;
               check("alu_instr", u_if.alu_instr, prog[k].op * 32);
               check("alu_a", u_if.alu_a, prog[k].a);
               check("alu_b", u_if.alu_b, prog[k].b);
            end
            if (t >= 5 && t <= 4 * run_n + 1 && (t - 5) % 4 == 0) begin
               k    = (t - 5) / 4;
               e_rv = (prog[k].op <= 5) ? 1 : 0;
               if (e_rv == 1 && res_valid) begin
                  check("res_idx", res_idx, k);
                  check("res_op", res_op, prog[k].op);
                  check("res_data", res_data, alu_fn(prog[k].op, prog[k].a, prog[k].b));
               end
            end
         end
         check("busy", busy, e_busy);
         check("done", done, e_done);
         check("res_valid", res_valid, e_rv);
         if (res_valid) begin
            obs_idx.push_back(int'(res_idx));
            obs_data.push_back(int'(res_data));
         end
         if (done) begin
            obs_done_t = t;
            obs_done_n++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_entry(input int addr, input int op, input int a, input int b);
      load_en    = 1'b1;
      load_addr  = 3'(addr);
      load_instr = {3'(op), 5'b10101};
      load_a     = 4'(a);
      load_b     = 4'(b);
      step();
      load_en    = 1'b0;
   endtask

   task automatic clear_obs();
      obs_idx.delete();
      obs_data.delete();
      obs_done_t = -1;
      obs_done_n = 0;
   endtask

   // Pulses start (any load already set up by the caller lands in the same cycle).
   task automatic run_prog(input int n);
      int ns;
      ns = (n > 8) ? 8 : n;
      clear_obs();
      count = 4'(n);
      start = 1'b1;
      step();
      start   = 1'b0;
      load_en = 1'b0;
      repeat (4 * ns + 3) step();
   endtask

   // Literal expectations for a finished run.
   task automatic check_obs(input string tag, input int e_done_t,
                            input int e_idx[$], input int e_data[$]);
      check({tag, "_npulses"}, obs_data.size(), e_data.size());
      for (int i = 0; i < e_data.size() && i < obs_data.size(); i++) begin
         check({tag, "_idx"}, obs_idx[i], e_idx[i]);
         check({tag, "_data"}, obs_data[i], e_data[i]);
      end
      check({tag, "_done_t"}, obs_done_t, e_done_t);
      check({tag, "_done_n"}, obs_done_n, 1);
   endtask

   initial begin
      int qi[$], qd[$];
      for (int i = 0; i < 8; i++) prog[i] = '{0, 0, 0};
      rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_instr = '0;
      load_a = '0; load_b = '0; count = '0; start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // 1: basic three-entry program
      load_entry(0, 0, 3, 5);
      load_entry(1, 1, 5, 0);
      load_entry(2, 2, 9, 0);
      run_prog(3);
      qi = '{0, 1, 2}; qd = '{8, 10, 2};
      check_obs("t1", 13, qi, qd);

      // 2: wrap, equality, greater-than
      load_entry(0, 0, 9, 8);
      load_entry(1, 4, 7, 7);
      load_entry(2, 5, 2, 9);
      run_prog(3);
      qi = '{0, 1, 2}; qd = '{1, 1, 0};
      check_obs("t2", 13, qi, qd);

      // 3: store opcode in the middle produces no pulse
      load_entry(0, 0, 1, 2);
      load_entry(1, 6, 4, 0);
      load_entry(2, 0, 7, 7);
      run_prog(3);
      qi = '{0, 2}; qd = '{3, 14};
      check_obs("t3", 13, qi, qd);

      // 4: empty run
      run_prog(0);
      qi = {}; qd = {};
      check_obs("t4", 1, qi, qd);

      // 5: start and load during a run are ignored
      load_entry(0, 0, 3, 5);
      load_entry(1, 1, 5, 0);
      load_entry(2, 2, 9, 0);
      clear_obs();
      count = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      step();
      start = 1'b1; load_en = 1'b1; load_addr = 3'd1; load_instr = 8'h00;
      load_a = 4'd15; load_b = 4'd15;
      step();
      start = 1'b0; load_en = 1'b0;
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (10) step();
      qi = '{0, 1, 2}; qd = '{8, 10, 2};
      check_obs("t5", 13, qi, qd);

      // 6: reset during WAIT of entry 1, then restart with a same-cycle load of entry 0
      clear_obs();
      count = 4'd3; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      check("pre_rst_alu_a", u_if.alu_a, 5);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_alu_a", u_if.alu_a, 0);
      check("abort_alu_instr", u_if.alu_instr, 0);
      check("abort_done", done, 0);
      repeat (2) step();
      rst_n = 1'b1;
      step();
      load_en = 1'b1; load_addr = 3'd0; load_instr = 8'h1F; load_a = 4'd6; load_b = 4'd7;
      run_prog(3);
      qi = '{0, 1, 2}; qd = '{13, 10, 2};
      check_obs("t6", 13, qi, qd);

      // 7: count above DEPTH saturates to a full eight-entry run
      for (int i = 0; i < 8; i++) load_entry(i, i, i + 1, 3);
      run_prog(15);
      qi = '{0, 1, 2, 3, 4, 5}; qd = '{4, 13, 6, 2, 0, 1};
      check_obs("t7", 33, qi, qd);

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no summary, expected completion");
      $fatal(1, "timeout");
   end

endmodule
